// File: rtl/demux_valid.sv
// rtl/demux_valid.sv - 1:2 round-robin stream demux into two FWFT lane FIFOs

module demux_valid_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  valid,
  output logic                  full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rptr;
  logic [AW-1:0]         wptr;
  logic [AW:0]           count;
  logic                  do_pop;

  assign valid  = (count != '0);
  assign full   = (count == FULL_CNT);
  assign rdata  = valid ? mem[rptr] : '0;
  // Pops of an empty lane are dropped so the pointers can never underflow.
  assign do_pop = pop & valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      if (push && !do_pop) count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end
endmodule

module demux_valid #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_0,
  output logic                  valid_0,
  input  logic                  pop_0,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic                  valid_1,
  input  logic                  pop_1,
  output logic                  sel
);
  logic full_0;
  logic full_1;
  logic push;

  // ready_in looks only at registered lane state, never at pops or valid_in.
  assign ready_in = sel ? !full_1 : !full_0;
  assign push     = valid_in & ready_in & !reset;

  always_ff @(posedge clk) begin
    if (reset) sel <= 1'b0;
    else if (push) sel <= !sel;
  end

  demux_valid_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lane_0 (
    .clk   (clk),
    .reset (reset),
    .push  (push & !sel),
    .wdata (data_in),
    .pop   (pop_0),
    .rdata (data_0),
    .valid (valid_0),
    .full  (full_0)
  );

  demux_valid_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lane_1 (
    .clk   (clk),
    .reset (reset),
    .push  (push & sel),
    .wdata (data_in),
    .pop   (pop_1),
    .rdata (data_1),
    .valid (valid_1),
    .full  (full_1)
  );
endmodule

// File: tb/tb_demux_valid.sv
// tb/tb_demux_valid.sv - randomized and directed bench for demux_valid against a queue model

module tb_demux_valid;
  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [DW-1:0] data_0;
  logic          valid_0;
  logic          pop_0 = 1'b0;
  logic [DW-1:0] data_1;
  logic          valid_1;
  logic          pop_1 = 1'b0;
  logic          sel;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          m_sel = 1'b0;

  demux_valid #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_0   (data_0),
    .valid_0  (valid_0),
    .pop_0    (pop_0),
    .data_1   (data_1),
    .valid_1  (valid_1),
    .pop_1    (pop_1),
    .sel      (sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: word k goes to lane k mod 2; a lane takes a word only while it holds < DEPTH.
  always @(posedge clk) begin
    bit rdy;
    if (reset) begin
      q0.delete();
      q1.delete();
      m_sel = 1'b0;
    end else begin
      rdy = m_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      if (pop_0 && q0.size() > 0) void'(q0.pop_front());
      if (pop_1 && q1.size() > 0) void'(q1.pop_front());
      if (valid_in && rdy) begin
        if (m_sel) q1.push_back(data_in);
        else q0.push_back(data_in);
        m_sel = !m_sel;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_in", 32'(ready_in), 32'(m_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("valid_0", 32'(valid_0), 32'(q0.size() > 0));
      chk("data_0", 32'(data_0), 32'(q0.size() > 0 ? q0[0] : 4'h0));
      chk("valid_1", 32'(valid_1), 32'(q1.size() > 0));
      chk("data_1", 32'(data_1), 32'(q1.size() > 0 ? q1[0] : 4'h0));
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic p0, input logic p1);
    valid_in = v;
    data_in  = d;
    pop_0    = p0;
    pop_1    = p1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // 1: reset with a word offered on the input
    reset = 1'b1;
    step(1'b1, 4'hF, 1'b1, 1'b1);
    chk_en = 1'b1;
    step(1'b1, 4'hF, 1'b1, 1'b1);
    chk("rst_valid_0", 32'(valid_0), 0);
    chk("rst_valid_1", 32'(valid_1), 0);
    chk("rst_data_0", 32'(data_0), 0);
    chk("rst_sel", 32'(sel), 0);
    reset = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_ready", 32'(ready_in), 1);
    chk("rst_empty", 32'(valid_0 | valid_1), 0);

    // 2: distribution
    step(1'b1, 4'h1, 1'b0, 1'b0);
    chk("dist_valid_0", 32'(valid_0), 1);
    chk("dist_data_0", 32'(data_0), 32'h1);
    chk("dist_sel1", 32'(sel), 1);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    chk("dist_sel2", 32'(sel), 0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    chk("dist_data_1", 32'(data_1), 32'h2);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("dist_lane0_2nd", 32'(data_0), 32'h3);
    chk("dist_lane1_2nd", 32'(data_1), 32'h4);

    // 3: back-pressure
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    chk("bp_ready_full", 32'(ready_in), 0);
    chk("bp_sel", 32'(sel), 0);
    step(1'b1, 4'h8, 1'b0, 1'b0);
    chk("bp_stall_sel", 32'(sel), 0);
    chk("bp_stall_head", 32'(data_0), 32'h0);
    step(1'b1, 4'h8, 1'b1, 1'b0);
    chk("bp_ready_after_pop", 32'(ready_in), 1);
    chk("bp_head_after_pop", 32'(data_0), 32'h2);
    step(1'b1, 4'h8, 1'b0, 1'b0);
    chk("bp_sel_after_accept", 32'(sel), 1);
    chk("bp_head_kept", 32'(data_0), 32'h2);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_tail_8", 32'(data_0), 32'h8);

    // 4: concurrent push and pop on lane 0
    do_reset(1);
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0);
    step(1'b1, 4'hB, 1'b1, 1'b0);
    chk("pp_data_0", 32'(data_0), 32'hB);
    chk("pp_sel", 32'(sel), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pp_count_was_1", 32'(valid_0), 0);

    // 5: pops on empty lanes
    do_reset(1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    chk("pe_valid_0", 32'(valid_0), 1);
    chk("pe_data_0", 32'(data_0), 32'h5);
    chk("pe_valid_1", 32'(valid_1), 0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pe_no_spurious", 32'(valid_0), 0);

    // 6: reset mid-operation
    do_reset(1);
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    do_reset(1);
    chk("mr_valid", 32'({valid_0, valid_1}), 0);
    chk("mr_sel", 32'(sel), 0);
    step(1'b1, 4'hC, 1'b0, 1'b0);
    chk("mr_data_0", 32'(data_0), 32'hC);
    chk("mr_valid_1", 32'(valid_1), 0);

    // randomized traffic with occasional reset
    do_reset(1);
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 3) != 0, 4'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    reset = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_valid.md
Name: demux_valid

Overview:
- Receive-side counterpart of the 2:1 valid-qualified round-robin mux.
- Takes one serialized data/valid stream and distributes accepted words alternately to lane 0 and lane 1, starting with lane 0.
- Each lane buffers words in a small first-word-fall-through (FWFT) FIFO drained by its consumer through a pop strobe.
- Back-pressures the upstream through ready_in when the lane currently targeted is full.

Parameters:
- DATA_WIDTH, 4, width of data_in, data_0 and data_1.
- DEPTH, 4, entries per lane FIFO; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  incoming word.
- valid_in  input  1  data_in qualifier.
- ready_in  output  1  block can accept a word into the currently selected lane.
- data_0  output  DATA_WIDTH  head word of lane 0 FIFO; 0 when lane empty.
- valid_0  output  1  lane 0 FIFO non-empty.
- pop_0  input  1  consumer takes the lane 0 head this cycle.
- data_1  output  DATA_WIDTH  head word of lane 1 FIFO; 0 when lane empty.
- valid_1  output  1  lane 1 FIFO non-empty.
- pop_1  input  1  consumer takes the lane 1 head this cycle.
- sel  output  1  lane the next accepted word goes to (0 or 1).

Behaviour:
- Reset (synchronous, checked at the rising edge with reset=1):
  - sel=0; both FIFOs flushed (read ptr = write ptr = count = 0).
  - valid_0=valid_1=0, data_0=data_1=0, ready_in=1 once reset deasserts.
  - Pops and valid_in are ignored while reset=1.
  - Reset mid-operation discards all buffered words; there is no partial drain.
- Accept rule:
  - push = valid_in & ready_in.
  - ready_in = !full[sel], purely from registered state. There is no combinational path from pop_x or valid_in to ready_in.
  - On push, data_in is written to FIFO[sel] and sel toggles at the same edge.
  - valid_in=1 with ready_in=0 is a stall: the word is not taken, sel holds, and upstream must hold the word.
- Output latency:
  - A word pushed at edge N appears on data_x with valid_x=1 immediately after edge N (1-cycle latency, FWFT).
  - data_x/valid_x depend only on registered state.
- Pop rule:
  - pop_x with valid_x=1 removes the head at the edge; the next entry, if any, is shown after that edge.
  - pop_x with valid_x=0 is ignored: no pointer movement, no underflow.
- Simultaneous events:
  - Push and pop on the same non-full lane in the same cycle: count unchanged, both pointers advance.
  - Push into a full lane is impossible because ready_in=0, even when the same cycle pops that lane. The word is accepted the following cycle.
  - Push to one lane and pop of the other lane are independent.
  - pop_0 and pop_1 together are both honoured.
- Width and arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Ordering guarantees:
  - Within a lane, words are strictly FIFO.
  - Across lanes, word k of the input stream (k from 0) lands in lane k mod 2, regardless of stalls.

Test Plan:
1. Reset: assert reset 2 cycles with valid_in=1 and data_in=4'hF -> valid_0=valid_1=0, data_0=data_1=0, sel=0; after release ready_in=1 and nothing is buffered.
2. Distribution: push 4'h1,4'h2,4'h3,4'h4 on consecutive cycles, no pops -> lane 0 holds 1,3 and lane 1 holds 2,4; valid_0 rises the cycle after the first push with data_0=1; sel toggles each cycle.
3. Back-pressure: with DEPTH=4, push 8 words 4'h0..4'h7 and never pop -> both lanes full, ready_in=0, sel=0. A 9th word 4'h8 is held; pop_0 once (removes 0) -> ready_in=1 the next cycle, 8 enters lane 0 behind 6, and data_0 shows 2.
4. Concurrent push/pop: lane 0 holds 1 word (4'hA); in one cycle push 4'hB (sel=0) and pop_0 -> data_0=B, count stays 1, then sel=1.
5. Pop empty: pop_0=pop_1=1 on empty lanes for 3 cycles, then push 4'h5 -> valid_0 rises with data_0=5 and no spurious entries appear in either lane.
6. Reset mid-op: fill lane 0 with 2 words and lane 1 with 1, assert reset 1 cycle -> both valid low and sel=0; the next push 4'hC goes to lane 0.
